fetch_unit: RTL and testbench

- Instruction fetch front end: owns the PC, issues word reads to instruction memory, and buffers returned words.
- Presents {inst, pc} to the decoder over a valid/ready handshake; the decoder's 32-bit `inst` input is fed from this block's `inst` output.
- Accepts branch/jump redirects from execute and discards wrong-path words.

---
 rtl/fetch_pkg.sv | 22 ++
 rtl/inst_buffer.sv | 60 ++++++
 rtl/fetch_unit.sv | 131 +++++++++++++
 tb/tb_fetch_unit.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
//   fetch_state_t : fetch FSM states (FETCH, FLUSH)
//   fetch_entry_t : one buffered instruction word together with its PC
//   INST_BYTES    : PC increment per fetched word
//   align_pc()    : forces a redirect target onto a word boundary
package fetch_pkg;
  localparam int INST_BYTES = 4;

  typedef enum logic [0:0] {
    FETCH = 1'b0,
    FLUSH = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } fetch_entry_t;

  function automatic logic [31:0] align_pc(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction
endpackage

// File: rtl/inst_buffer.sv
// Circular instruction FIFO between the memory side and the decoder.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   push, wdata  : write one entry (caller guarantees space, or pop this cycle)
//   pop          : drop head entry (ignored when empty)
//   flush        : empty the buffer; wins over push/pop
//   rdata        : head entry, read straight from registered storage
//   full, empty, count : occupancy status
module inst_buffer
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  fetch_entry_t             wdata,
  output fetch_entry_t             rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  fetch_entry_t   r_mem [DEPTH];
  logic [AW-1:0]  r_wr_ptr;
  logic [AW-1:0]  r_rd_ptr;
  logic [AW:0]    r_count;
  logic           w_pop;

  assign w_pop = pop && (r_count != '0);

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push) begin
        r_mem[r_wr_ptr] <= wdata;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + {{AW{1'b0}}, push} - {{AW{1'b0}}, w_pop};
    end
  end

  assign rdata = r_mem[r_rd_ptr];
  assign count = r_count;
  assign full  = (r_count == (AW+1)'(DEPTH));
  assign empty = (r_count == '0);
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: owns the PC, issues word reads to instruction
// memory, buffers returned words and hands {inst, inst_pc} to the decoder.
// Ports:
//   clk, rst                    : clock, synchronous active-high reset
//   imem_req/imem_addr          : read request, held stable until imem_ack
//   imem_ack/imem_rdata         : transfer completes on req && ack
//   redirect_valid/redirect_pc  : taken branch/jump from execute
//   inst_valid/inst/inst_pc     : buffer head to decoder
//   inst_ready                  : decoder consumes head this cycle
// Optional (macro FETCH_PERF_EN):
//   perf_fetched : words pushed into the buffer
//   perf_stall   : cycles with imem_req && !imem_ack
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stall
`endif
);
  localparam int CW = $clog2(BUF_DEPTH) + 1;

  fetch_state_t r_state, w_next_state;
  logic [31:0]  r_pc, r_pend_pc;
  logic         w_pop, w_push, w_xfer, w_full, w_empty;
  logic [CW-1:0] w_count;
  fetch_entry_t w_wdata, w_head;

  assign w_pop   = inst_valid && inst_ready;
  assign w_xfer  = imem_req && imem_ack;
  // Words acked in FLUSH or alongside a redirect are wrong-path: never pushed.
  assign w_push  = (r_state == FETCH) && w_xfer && !redirect_valid && (!w_full || w_pop);
  assign w_wdata = '{inst: imem_rdata, pc: r_pc};

  inst_buffer #(.DEPTH(BUF_DEPTH)) u_buf (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_pop),
    .flush (redirect_valid),
    .wdata (w_wdata),
    .rdata (w_head),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= FETCH;
    else     r_state <= w_next_state;
  end

  // Next-state logic: a redirect that lands on an outstanding request must
  // wait for that request's ack before the new PC can be issued.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      FETCH: if (redirect_valid && imem_req && !imem_ack) w_next_state = FLUSH;
      FLUSH: if (w_xfer) w_next_state = FETCH;
      default: w_next_state = FETCH;
    endcase
  end

  // Outputs. A request raised for a free slot stays raised: occupancy only
  // drops without an ack. A request raised by a pop when full likewise finds
  // a free slot next cycle. FLUSH always holds its pending request.
  always_comb begin
    imem_req = 1'b0;
    if (!rst) begin
      case (r_state)
        FETCH:   imem_req = (w_count < CW'(BUF_DEPTH)) || w_pop;
        FLUSH:   imem_req = 1'b1;
        default: imem_req = 1'b0;
      endcase
    end
  end

  assign imem_addr  = r_pc;
  assign inst_valid = !w_empty;
  assign inst       = w_head.inst;
  assign inst_pc    = w_head.pc;

  // PC and pending-redirect target. r_pc is the address on the bus, so it
  // must not move while a request is outstanding in FLUSH.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc      <= RESET_PC;
      r_pend_pc <= '0;
    end else if (r_state == FETCH) begin
      if (redirect_valid) begin
        if (imem_req && !imem_ack) r_pend_pc <= align_pc(redirect_pc);
        else                       r_pc      <= align_pc(redirect_pc);
      end else if (w_xfer) begin
        r_pc <= r_pc + 32'(INST_BYTES);
      end
    end else begin
      // Last redirect wins, including one arriving on the ack cycle.
      if (w_xfer)              r_pc      <= redirect_valid ? align_pc(redirect_pc) : r_pend_pc;
      else if (redirect_valid) r_pend_pc <= align_pc(redirect_pc);
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched <= '0;
      perf_stall   <= '0;
    end else begin
      if (w_push)                perf_fetched <= perf_fetched + 32'd1;
      if (imem_req && !imem_ack) perf_stall   <= perf_stall + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
  localparam int          D   = 2;
  localparam logic [31:0] RPC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready = 1'b0;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched, perf_stall;
  logic [31:0] m_fetched, m_stall;
`endif

  always #5 clk = ~clk;

  // Memory returns addr+1 so every word identifies its own address.
  assign imem_rdata = imem_addr + 32'd1;

  fetch_unit #(.RESET_PC(RPC), .BUF_DEPTH(D)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_ready     (inst_ready)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_stall     (perf_stall)
`endif
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference model: fetch address, pending redirect, buffer occupancy, and a
  // scoreboard of words accepted into the buffer in program order.
  typedef struct { logic [31:0] inst; logic [31:0] pc; } exp_t;
  exp_t        exp_q[$];
  logic [31:0] m_pc = RPC, m_pend = '0;
  bit          m_flush = 0;
  int          m_cnt = 0;
  bit          started = 0, last_rst = 0;

  function automatic bit m_req();
    return m_flush || (m_cnt < D) || (m_cnt > 0 && inst_ready);
  endfunction

  task automatic model_step();
    bit req, pop, xfer;
    logic [31:0] tgt;
    last_rst = rst;
    if (rst) begin
      started = 1; m_pc = RPC; m_pend = '0; m_flush = 0; m_cnt = 0;
      exp_q.delete();
`ifdef FETCH_PERF_EN
      m_fetched = '0; m_stall = '0;
`endif
      return;
    end
    req  = m_req();
    pop  = (m_cnt > 0) && inst_ready;
    xfer = req && imem_ack;
    tgt  = redirect_pc & 32'hFFFF_FFFC;
`ifdef FETCH_PERF_EN
    if (req && !imem_ack) m_stall++;
`endif
    if (m_flush) begin
      if (redirect_valid) exp_q.delete();
      if (xfer) begin m_pc = redirect_valid ? tgt : m_pend; m_flush = 0; end
      else if (redirect_valid) m_pend = tgt;
    end else if (redirect_valid) begin
      exp_q.delete(); m_cnt = 0;
      if (req && !imem_ack) begin m_flush = 1; m_pend = tgt; end
      else m_pc = tgt;
    end else begin
      if (pop) m_cnt--;
      if (xfer) begin
        exp_q.push_back('{m_pc + 32'd1, m_pc});
        m_cnt++;
        m_pc = m_pc + 32'd4;
`ifdef FETCH_PERF_EN
        m_fetched++;
`endif
      end
    end
  endtask

  always @(posedge clk) model_step();

  // Monitor: compares the bus and pops the scoreboard on every handshake.
  always @(negedge clk) begin
    if (rst) begin
      if (last_rst) begin
        chk("rst_req",   32'(imem_req),   32'd0);
        chk("rst_valid", 32'(inst_valid), 32'd0);
        chk("rst_inst",  inst,            32'd0);
        chk("rst_pc",    inst_pc,         32'd0);
        chk("rst_addr",  imem_addr,       RPC);
      end
    end else if (started) begin
      chk("imem_req",   32'(imem_req),   32'(m_req()));
      chk("imem_addr",  imem_addr,       m_pc);
      chk("inst_valid", 32'(inst_valid), 32'(m_cnt != 0));
      if (inst_valid && inst_ready) begin
        chk("sb_nonempty", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          exp_t e;
          e = exp_q.pop_front();
          chk("inst",    inst,    e.inst);
          chk("inst_pc", inst_pc, e.pc);
        end
      end
    end
  end

  task automatic drive(input bit a, input bit r, input bit rv, input logic [31:0] p, input bit rs = 0);
    @(posedge clk);
    #1;
    imem_ack = a; inst_ready = r; redirect_valid = rv; redirect_pc = p; rst = rs;
  endtask

  initial begin
    logic [31:0] p;
    repeat (3) @(posedge clk);
    // Streaming: back-to-back delivery from RESET_PC.
    drive(0, 0, 0, 0);
    repeat (10) drive(1, 1, 0, 0);
    // Back-pressure: fills, drops req, then resumes in order.
    repeat (6) drive(1, 0, 0, 0);
    repeat (4) drive(1, 1, 0, 0);
    // Redirect with no request pending (buffer full, decoder stalled).
    repeat (4) drive(1, 0, 0, 0);
    drive(1, 0, 1, 32'h0000_0100);
    drive(1, 1, 0, 0);
    @(negedge clk);
    chk("idle_redir_addr",  imem_addr,       32'h0000_0100);
    chk("idle_redir_valid", 32'(inst_valid), 32'd0);
    repeat (4) drive(1, 1, 0, 0);
    // Redirects while a request is pending: last one wins.
    repeat (3) drive(0, 1, 0, 0);
    drive(0, 1, 1, 32'h0000_0200);
    drive(0, 1, 0, 0);
    drive(0, 1, 1, 32'h0000_0300);
    drive(1, 1, 0, 0);
    drive(1, 1, 0, 0);
    @(negedge clk);
    chk("pend_redir_addr", imem_addr, 32'h0000_0300);
    repeat (3) drive(1, 1, 0, 0);
    // Unaligned target and PC wrap.
    drive(1, 1, 1, 32'h0000_0103);
    drive(1, 1, 1, 32'hFFFF_FFFC);
    @(negedge clk);
    chk("align_addr", imem_addr, 32'h0000_0100);
    drive(1, 1, 0, 0);
    @(negedge clk);
    chk("wrap_start", imem_addr, 32'hFFFF_FFFC);
    drive(1, 1, 0, 0);
    @(negedge clk);
    chk("wrap_addr", imem_addr, 32'h0000_0000);
    repeat (3) drive(1, 1, 0, 0);
    // Random traffic with occasional mid-run reset.
    for (int i = 0; i < 3000; i++) begin
      p = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
      drive($urandom_range(0, 9) < 6, $urandom_range(0, 9) < 7,
            $urandom_range(0, 15) == 0, p, $urandom_range(0, 499) == 0);
    end
    drive(0, 0, 0, 0);
    @(negedge clk);
`ifdef FETCH_PERF_EN
    chk("perf_fetched", perf_fetched, m_fetched);
    chk("perf_stall",   perf_stall,   m_stall);
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
